// File: rtl/bus_frame_pkg.sv
// Constants and state encoding shared by the frame receiver and the injector.
// Also holds the bit-placement helper used when assembling tail bytes.
package bus_frame_pkg;

    localparam int HDR_BITS   = 24;
    localparam int BYTE_BITS  = 8;
    localparam int FRAME_BITS = 40;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        DATA = 2'd1,
        CSUM = 2'd2
    } frame_state_e;

    // Returns byte b with bit position pos replaced by v.
    function automatic logic [BYTE_BITS-1:0] put_bit(input logic [BYTE_BITS-1:0] b,
                                                     input logic [2:0]           pos,
                                                     input logic                 v);
        logic [BYTE_BITS-1:0] r;
        r      = b;
        r[pos] = v;
        return r;
    endfunction

endpackage

// File: rtl/frame_cksum_acc.sv
// Mod-256 byte accumulator with synchronous clear (dominant) and add enable.
module frame_cksum_acc
    import bus_frame_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 clr_i,
    input  logic                 add_en_i,
    input  logic [BYTE_BITS-1:0] byte_i,
    output logic [BYTE_BITS-1:0] sum_o
);

    logic [BYTE_BITS-1:0] sum_q;

    // Running sum register; wraps naturally at 8 bits.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sum_q <= 8'h00;
        end else if (clr_i) begin
            sum_q <= 8'h00;
        end else if (add_en_i) begin
            sum_q <= sum_q + byte_i;
        end else begin
            sum_q <= sum_q;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/bus_frame_rx.sv
// Serial 5-byte frame receiver: header/data/checksum capture, checksum and
// header-match evaluation, valid/ack presentation and saturating statistics.
module bus_frame_rx
    import bus_frame_pkg::*;
#(
    parameter logic [23:0] HDR_MATCH      = 24'h000000,
    parameter logic [23:0] HDR_MASK       = 24'hFFFFFF,
    parameter bit          TAIL_LSB_FIRST = 1'b1,
    parameter int          CNT_W          = 16
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             data_in,
    input  logic             rx_en,
    input  logic             frame_ack,
    output logic             frame_valid,
    output logic [23:0]      hdr_out,
    output logic [7:0]       data_out,
    output logic [7:0]       csum_out,
    output logic             csum_ok,
    output logic             hdr_match,
    output logic             overrun,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    frame_state_e          state_q, state_d;
    logic [5:0]            bit_idx_q, bit_idx_d;
    logic [HDR_BITS-1:0]   hdr_sr_q, hdr_sr_d;
    logic [BYTE_BITS-1:0]  data_sr_q, data_sr_d;
    logic [BYTE_BITS-1:0]  csum_sr_q, csum_sr_d;
    logic [2:0]            tail_pos_s;
    logic                  acc_clr_s, acc_add_s, done_s;
    logic [BYTE_BITS-1:0]  acc_byte_s, acc_sum_s;
    logic                  csum_ok_s, hdr_match_s;

    logic                  frame_valid_q, frame_valid_d;
    logic [HDR_BITS-1:0]   hdr_out_q, hdr_out_d;
    logic [BYTE_BITS-1:0]  data_out_q, data_out_d, csum_out_q, csum_out_d;
    logic                  csum_ok_q, csum_ok_d, hdr_match_q, hdr_match_d;
    logic                  overrun_q, overrun_d;
    logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;

    frame_cksum_acc u_acc (
        .clk_in   (clk_in),
        .reset    (reset),
        .clr_i    (acc_clr_s),
        .add_en_i (acc_add_s),
        .byte_i   (acc_byte_s),
        .sum_o    (acc_sum_s)
    );

    // Receive FSM: bit counting, shift registers and accumulator control.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        hdr_sr_d   = hdr_sr_q;
        data_sr_d  = data_sr_q;
        csum_sr_d  = csum_sr_q;
        acc_clr_s  = 1'b0;
        acc_add_s  = 1'b0;
        acc_byte_s = 8'h00;
        done_s     = 1'b0;
        tail_pos_s = TAIL_LSB_FIRST ? bit_idx_q[2:0] : ~bit_idx_q[2:0];
        if (!rx_en) begin
            state_d   = HDR;
            bit_idx_d = 6'd0;
            acc_clr_s = 1'b1;
        end else begin
            case (state_q)
                HDR: begin
                    hdr_sr_d  = {hdr_sr_q[HDR_BITS-2:0], data_in};
                    bit_idx_d = bit_idx_q + 6'd1;
                    // Header byte boundaries fall on bit_idx 7, 15, 23.
                    if (bit_idx_q[2:0] == 3'd7) begin
                        acc_add_s  = 1'b1;
                        acc_byte_s = {hdr_sr_q[6:0], data_in};
                    end else begin
                        acc_add_s  = 1'b0;
                    end
                    if (bit_idx_q == 6'(HDR_BITS - 1)) begin
                        state_d = DATA;
                    end else begin
                        state_d = HDR;
                    end
                end
                DATA: begin
                    data_sr_d = put_bit(data_sr_q, tail_pos_s, data_in);
                    bit_idx_d = bit_idx_q + 6'd1;
                    if (bit_idx_q == 6'(HDR_BITS + BYTE_BITS - 1)) begin
                        acc_add_s  = 1'b1;
                        acc_byte_s = data_sr_d;
                        state_d    = CSUM;
                    end else begin
                        state_d    = DATA;
                    end
                end
                CSUM: begin
                    csum_sr_d = put_bit(csum_sr_q, tail_pos_s, data_in);
                    if (bit_idx_q == 6'(FRAME_BITS - 1)) begin
                        done_s    = 1'b1;
                        acc_clr_s = 1'b1;
                        bit_idx_d = 6'd0;
                        state_d   = HDR;
                    end else begin
                        bit_idx_d = bit_idx_q + 6'd1;
                        state_d   = CSUM;
                    end
                end
                default: begin
                    state_d   = HDR;
                    bit_idx_d = 6'd0;
                    acc_clr_s = 1'b1;
                end
            endcase
        end
    end

    assign csum_ok_s   = (csum_sr_d == acc_sum_s);
    assign hdr_match_s = (((hdr_sr_q ^ HDR_MATCH) & HDR_MASK) == 24'h000000);

    // Presentation, handshake, overrun and statistics next-state.
    always_comb begin
        hdr_out_d   = hdr_out_q;
        data_out_d  = data_out_q;
        csum_out_d  = csum_out_q;
        csum_ok_d   = csum_ok_q;
        hdr_match_d = hdr_match_q;
        overrun_d   = overrun_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (frame_valid_q && frame_ack) begin
            frame_valid_d = 1'b0;
        end else begin
            frame_valid_d = frame_valid_q;
        end
        if (done_s) begin
            frame_valid_d = 1'b1;
            hdr_out_d     = hdr_sr_q;
            data_out_d    = data_sr_q;
            csum_out_d    = csum_sr_d;
            csum_ok_d     = csum_ok_s;
            hdr_match_d   = hdr_match_s;
            if (frame_valid_q && !frame_ack) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
            if (frame_cnt_q != {CNT_W{1'b1}}) begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end else begin
                frame_cnt_d = frame_cnt_q;
            end
            if (!csum_ok_s && (err_cnt_q != {CNT_W{1'b1}})) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            overrun_d = overrun_q;
        end
    end

    // All state and output registers.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q       <= HDR;
            bit_idx_q     <= 6'd0;
            hdr_sr_q      <= 24'h000000;
            data_sr_q     <= 8'h00;
            csum_sr_q     <= 8'h00;
            frame_valid_q <= 1'b0;
            hdr_out_q     <= 24'h000000;
            data_out_q    <= 8'h00;
            csum_out_q    <= 8'h00;
            csum_ok_q     <= 1'b0;
            hdr_match_q   <= 1'b0;
            overrun_q     <= 1'b0;
            frame_cnt_q   <= {CNT_W{1'b0}};
            err_cnt_q     <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            bit_idx_q     <= bit_idx_d;
            hdr_sr_q      <= hdr_sr_d;
            data_sr_q     <= data_sr_d;
            csum_sr_q     <= csum_sr_d;
            frame_valid_q <= frame_valid_d;
            hdr_out_q     <= hdr_out_d;
            data_out_q    <= data_out_d;
            csum_out_q    <= csum_out_d;
            csum_ok_q     <= csum_ok_d;
            hdr_match_q   <= hdr_match_d;
            overrun_q     <= overrun_d;
            frame_cnt_q   <= frame_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign hdr_out     = hdr_out_q;
    assign data_out    = data_out_q;
    assign csum_out    = csum_out_q;
    assign csum_ok     = csum_ok_q;
    assign hdr_match   = hdr_match_q;
    assign overrun     = overrun_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_bus_frame_rx.sv
// Scoreboard bench for bus_frame_rx: directed frames push expected results,
// per-DUT monitors pop and compare whenever a new frame is presented.
module tb_bus_frame_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        data_in = 1'b0;
    logic        rx_en1 = 1'b0, rx_en2 = 1'b0;
    logic        ack1 = 1'b0, ack2 = 1'b0;

    logic        v1, ok1, m1, ov1;
    logic [23:0] h1;
    logic [7:0]  d1, c1;
    logic [15:0] fc1, ec1;

    logic        v2, ok2, m2, ov2;
    logic [23:0] h2;
    logic [7:0]  d2, c2;
    logic [1:0]  fc2, ec2;

    int tests = 0;
    int failed = 0;

    typedef struct {
        logic [23:0] hdr;
        logic [7:0]  data;
        logic [7:0]  csum;
        logic        ok;
        logic        match;
        logic        ovr;
        int          cnt;
        int          err;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    bus_frame_rx dut1 (
        .clk_in(clk), .reset(reset), .data_in(data_in), .rx_en(rx_en1), .frame_ack(ack1),
        .frame_valid(v1), .hdr_out(h1), .data_out(d1), .csum_out(c1), .csum_ok(ok1),
        .hdr_match(m1), .overrun(ov1), .frame_cnt(fc1), .err_cnt(ec1)
    );

    bus_frame_rx #(
        .HDR_MATCH(24'hA10000), .HDR_MASK(24'hFF0000), .TAIL_LSB_FIRST(1'b1), .CNT_W(2)
    ) dut2 (
        .clk_in(clk), .reset(reset), .data_in(data_in), .rx_en(rx_en2), .frame_ack(ack2),
        .frame_valid(v2), .hdr_out(h2), .data_out(d2), .csum_out(c2), .csum_ok(ok2),
        .hdr_match(m2), .overrun(ov2), .frame_cnt(fc2), .err_cnt(ec2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the default-parameter instance.
    logic        pv1 = 1'b0;
    logic [39:0] pt1 = 40'h0;
    always @(negedge clk) begin
        exp_t e;
        if (v1 && (!pv1 || ({h1, d1, c1} != pt1))) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_frame", 64'(h1), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = q1.pop_front();
                check("dut1_hdr", 64'(h1), 64'(e.hdr));
                check("dut1_data", 64'(d1), 64'(e.data));
                check("dut1_csum", 64'(c1), 64'(e.csum));
                check("dut1_csum_ok", 64'(ok1), 64'(e.ok));
                check("dut1_hdr_match", 64'(m1), 64'(e.match));
                check("dut1_overrun", 64'(ov1), 64'(e.ovr));
                check("dut1_frame_cnt", 64'(fc1), 64'(e.cnt));
                check("dut1_err_cnt", 64'(ec1), 64'(e.err));
            end
        end
        pv1 <= v1;
        pt1 <= {h1, d1, c1};
    end

    // Monitor for the masked-match, 2-bit-counter instance.
    logic        pv2 = 1'b0;
    logic [39:0] pt2 = 40'h0;
    always @(negedge clk) begin
        exp_t e;
        if (v2 && (!pv2 || ({h2, d2, c2} != pt2))) begin
            if (q2.size() == 0) begin
                check("dut2_unexpected_frame", 64'(h2), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = q2.pop_front();
                check("dut2_hdr", 64'(h2), 64'(e.hdr));
                check("dut2_data", 64'(d2), 64'(e.data));
                check("dut2_csum_ok", 64'(ok2), 64'(e.ok));
                check("dut2_hdr_match", 64'(m2), 64'(e.match));
                check("dut2_frame_cnt", 64'(fc2), 64'(e.cnt));
                check("dut2_err_cnt", 64'(ec2), 64'(e.err));
            end
        end
        pv2 <= v2;
        pt2 <= {h2, d2, c2};
    end

    function automatic exp_t mk(input logic [23:0] h, input logic [7:0] d, input logic [7:0] c,
                                input logic ok, input logic m, input logic ov,
                                input int cnt, input int err);
        exp_t e;
        e.hdr = h; e.data = d; e.csum = c; e.ok = ok; e.match = m; e.ovr = ov;
        e.cnt = cnt; e.err = err;
        return e;
    endfunction

    // Sends nbits of a frame (header MSB first, tail LSB first), then idles rx_en low.
    task automatic send(input int sel, input logic [23:0] h, input logic [7:0] d,
                        input logic [7:0] c, input int nbits, input logic ack_last);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            if (sel == 0) rx_en1 = 1'b1; else rx_en2 = 1'b1;
            if (i < 24)      data_in = h[23-i];
            else if (i < 32) data_in = d[i-24];
            else             data_in = c[i-32];
            if (i == 39 && sel == 0) ack1 = ack_last;
        end
        @(negedge clk);
        rx_en1 = 1'b0;
        rx_en2 = 1'b0;
        ack1   = 1'b0;
    endtask

    task automatic ack(input int sel);
        @(negedge clk);
        if (sel == 0) ack1 = 1'b1; else ack2 = 1'b1;
        @(negedge clk);
        ack1 = 1'b0;
        ack2 = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, 64'(v1), 64'h0);
        check({tag, "_hdr"}, 64'(h1), 64'h0);
        check({tag, "_overrun"}, 64'(ov1), 64'h0);
        check({tag, "_frame_cnt"}, 64'(fc1), 64'h0);
        check({tag, "_err_cnt"}, 64'(ec1), 64'h0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_cleared("reset");
        check("reset_dut2_cnt", 64'(fc2), 64'h0);
        reset = 1'b0;

        // Good frame: A1+B2+C3+2B = 0x241 -> checksum 0x41.
        q1.push_back(mk(24'hA1B2C3, 8'h2B, 8'h41, 1'b1, 1'b0, 1'b0, 1, 0));
        send(0, 24'hA1B2C3, 8'h2B, 8'h41, 40, 1'b0);
        ack(0);

        // Same frame with a wrong checksum.
        q1.push_back(mk(24'hA1B2C3, 8'h2B, 8'hC1, 1'b0, 1'b0, 1'b0, 2, 1));
        send(0, 24'hA1B2C3, 8'h2B, 8'hC1, 40, 1'b0);
        ack(0);

        // Two frames without ack: second overwrites and raises overrun.
        q1.push_back(mk(24'h123456, 8'h78, 8'h14, 1'b1, 1'b0, 1'b0, 3, 1));
        send(0, 24'h123456, 8'h78, 8'h14, 40, 1'b0);
        q1.push_back(mk(24'h000000, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 4, 1));
        send(0, 24'h000000, 8'h00, 8'h00, 40, 1'b0);
        check("overrun_sticky", 64'(ov1), 64'h1);

        @(negedge clk); reset = 1'b1;
        @(negedge clk); check_cleared("reset2"); reset = 1'b0;

        // Second frame completes on the ack edge: no overrun, valid stays high.
        q1.push_back(mk(24'hA1B2C3, 8'h2B, 8'h41, 1'b1, 1'b0, 1'b0, 1, 0));
        send(0, 24'hA1B2C3, 8'h2B, 8'h41, 40, 1'b0);
        q1.push_back(mk(24'h0F0F0F, 8'hF0, 8'h1D, 1'b1, 1'b0, 1'b0, 2, 0));
        send(0, 24'h0F0F0F, 8'hF0, 8'h1D, 40, 1'b1);
        check("ack_on_completion_valid", 64'(v1), 64'h1);
        check("ack_on_completion_overrun", 64'(ov1), 64'h0);
        ack(0);
        check("ack_clears_valid", 64'(v1), 64'h0);

        // Reset in the middle of a frame (after 17 bits).
        send(0, 24'hFFFFFF, 8'hFF, 8'hFF, 17, 1'b0);
        reset = 1'b1;
        @(negedge clk); check_cleared("reset_midframe"); reset = 1'b0;
        q1.push_back(mk(24'hC0FFEE, 8'h11, 8'hBE, 1'b1, 1'b0, 1'b0, 1, 0));
        send(0, 24'hC0FFEE, 8'h11, 8'hBE, 40, 1'b0);
        ack(0);

        // rx_en dropped after 30 bits: presentation untouched, partial frame lost.
        send(0, 24'hAAAAAA, 8'h55, 8'h00, 30, 1'b0);
        repeat (2) @(negedge clk);
        check("rxen_drop_valid", 64'(v1), 64'h0);
        check("rxen_drop_hdr", 64'(h1), 64'hC0FFEE);
        check("rxen_drop_data", 64'(d1), 64'h11);
        check("rxen_drop_cnt", 64'(fc1), 64'h1);
        q1.push_back(mk(24'h010203, 8'h04, 8'h0A, 1'b1, 1'b0, 1'b0, 2, 0));
        send(0, 24'h010203, 8'h04, 8'h0A, 40, 1'b0);
        ack(0);

        // Masked header match and 2-bit counter saturation on dut2.
        q2.push_back(mk(24'hA1FFFF, 8'h00, 8'h9F, 1'b1, 1'b1, 1'b0, 1, 0));
        send(1, 24'hA1FFFF, 8'h00, 8'h9F, 40, 1'b0);
        ack(1);
        q2.push_back(mk(24'h11B2C3, 8'h2B, 8'hB1, 1'b1, 1'b0, 1'b0, 2, 0));
        send(1, 24'h11B2C3, 8'h2B, 8'hB1, 40, 1'b0);
        ack(1);
        q2.push_back(mk(24'hA10000, 8'h01, 8'hA2, 1'b1, 1'b1, 1'b0, 3, 0));
        send(1, 24'hA10000, 8'h01, 8'hA2, 40, 1'b0);
        ack(1);
        q2.push_back(mk(24'hA10000, 8'h02, 8'hA3, 1'b1, 1'b1, 1'b0, 3, 0));
        send(1, 24'hA10000, 8'h02, 8'hA3, 40, 1'b0);
        ack(1);

        repeat (4) @(negedge clk);
        check("dut1_queue_drained", 64'(q1.size()), 64'h0);
        check("dut2_queue_drained", 64'(q2.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
